sub_bytes_seq: RTL and testbench
================================

// Module: sub_bytes_seq
// PURPOSE
//   Iterative AES SubBytes / InvSubBytes stage. Accepts a 128-bit state, substitutes
//   LANES bytes per cycle through FIPS-197 S-box (or inverse S-box) logic, and presents
//   the result to the ShiftRows stage directly downstream. Valid/ready on both sides.
//   Trades area (LANES S-box instances instead of 16) for latency.
// PARAMETERS
//   LANES  4  bytes substituted per cycle; legal values 1,2,4,8,16 (must divide 16)
// PORTS
//   clk      in   1    system clock, all logic on rising edge
//   rst      in   1    synchronous, active-high reset
//   i_valid  in   1    upstream presents i_data/i_inv
//   o_ready  out  1    block can accept a new state
//   i_data   in   128  input state; byte k = i_data[127-8k -: 8], k=0..15
//   i_inv    in   1    1 = InvSubBytes (decrypt), 0 = SubBytes; sampled at accept
//   o_valid  out  1    o_data holds a complete substituted state
//   i_ready  in   1    downstream (ShiftRows side) accepts o_data
//   o_data   out  128  substituted state, same byte ordering as i_data
// BEHAVIOUR
//   - One clock (clk); reset synchronous, active-high (rst). Reset wins over all events.
//   - After reset edge: state=IDLE, o_ready=1, o_valid=0, o_data=128'h0, cnt=0, inv flag=0.
//   - N = 16/LANES. cnt is log2(N) bits wide (1 bit min); wraps only via explicit clear.
//   - FSM IDLE -> BUSY -> DONE -> IDLE:
//     IDLE: o_ready=1, o_valid=0. On i_valid: latch i_data into work reg (drives o_data),
//           latch i_inv, cnt<=0, go BUSY. No i_valid: hold.
//     BUSY: o_ready=0, o_valid=0. Each cycle replace bytes k = cnt*LANES .. cnt*LANES+LANES-1
//           of the work reg with S(byte) or InvS(byte) per latched inv flag; cnt++.
//           On the cycle cnt==N-1 the final group is written and state goes DONE.
//     DONE: o_valid=1, o_ready=0, o_data stable. On i_ready: go IDLE (o_valid low next
//           cycle). No accept in the same cycle as the output handshake.
//   - Latency: o_valid rises exactly N cycles after the accepting clk edge
//     (LANES=4 -> 4; LANES=16 -> 1). Throughput: one state per N+2 cycles minimum.
//   - o_ready and o_valid are decoded from state register only (no combinational
//     path from i_valid/i_ready).
//   - i_valid/i_data/i_inv ignored outside IDLE; i_ready ignored outside DONE.
//   - o_data mid-BUSY shows partially substituted state; undefined for consumers
//     unless o_valid=1.
//   - S-box: multiplicative inverse in GF(2^8) mod x^8+x^4+x^3+x+1 (0 maps to 0),
//     then affine transform with constant 8'h63. InvS: inverse affine (constant 8'h05),
//     then GF inverse. Any implementation bit-exact to FIPS-197 tables is acceptable.
//   - rst asserted in BUSY or DONE: abandon state, outputs to reset values next edge.
// TESTING
//   1 FIPS-197 App.B: i_data=128'h193de3bea0f4e22b9ac68d2ae9f84808, i_inv=0 ->
//     o_data=128'hd42711aee0bf98f1b8b45de51e415230, o_valid 4 cycles after accept.
//   2 Inverse: i_data=128'hd42711aee0bf98f1b8b45de51e415230, i_inv=1 ->
//     o_data=128'h193de3bea0f4e22b9ac68d2ae9f84808.
//   3 Corners: i_data all 8'h00 -> all 8'h63; all 8'hFF -> all 8'h16; inv of all
//     8'h63 -> all 8'h00; 8'h53 -> 8'hED per byte.
//   4 Backpressure: hold i_ready=0 for 10 cycles in DONE -> o_valid and o_data stable,
//     o_ready=0; toggled i_valid/i_data in BUSY/DONE do not alter result.
//   5 rst pulse at 2nd BUSY cycle -> next edge o_valid=0, o_ready=1, o_data=0;
//     following transaction correct.
//   6 Sweep LANES=1,2,8,16 with vector 1 -> same o_data; latency 16,8,2,1 cycles.
//     Exhaustive 256-value S/InvS check against reference table model.

Source files
------------

// File: rtl/sub_bytes_seq_if.sv
// Valid/ready bus carrying one 128-bit AES state into and out of sub_bytes_seq.
// The slave side is the substitution stage; the master side is its environment.
interface sub_bytes_seq_if;
    logic         i_valid;
    logic         o_ready;
    logic [127:0] i_data;
    logic         i_inv;
    logic         o_valid;
    logic         i_ready;
    logic [127:0] o_data;

    modport master (
        output i_valid, i_data, i_inv, i_ready,
        input  o_ready, o_valid, o_data
    );

    modport slave (
        input  i_valid, i_data, i_inv, i_ready,
        output o_ready, o_valid, o_data
    );
endinterface

// File: rtl/sub_bytes_seq.sv
// Iterative AES SubBytes/InvSubBytes: LANES bytes per cycle through computed S-box logic,
// full state presented downstream with valid/ready once all 16 bytes are substituted.
module sub_bytes_seq #(
    parameter int unsigned LANES = 4
) (
    input  logic             clk,
    input  logic             rst,
    sub_bytes_seq_if.slave   bus
);
    localparam int unsigned N  = 16 / LANES;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         state_q, state_d;
    logic [127:0]   work_q, work_d;
    logic [CW-1:0]  cnt_q;
    logic           inv_q;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // a^254 = a^-1 for a != 0, and naturally maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int unsigned i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] a, input int unsigned s);
        return (a << s) | (a >> (8 - s));
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] a);
        return a ^ rotl(a, 1) ^ rotl(a, 2) ^ rotl(a, 3) ^ rotl(a, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] a);
        return rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a, input logic inv);
        return inv ? gf_inv(inv_affine(a)) : affine(gf_inv(a));
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.i_valid) state_d = BUSY;
            BUSY:    if (cnt_q == CW'(N - 1)) state_d = DONE;
            DONE:    if (bus.i_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.o_ready = (state_q == IDLE);
        bus.o_valid = (state_q == DONE);
    end

    // Only the byte group selected by cnt is rewritten; the rest of the state passes through.
    always_comb begin
        int unsigned idx;
        idx    = 0;
        work_d = work_q;
        for (int unsigned l = 0; l < LANES; l++) begin
            idx = 32'(cnt_q) * LANES + l;
            work_d[127 - 8*idx -: 8] = sbox(work_q[127 - 8*idx -: 8], inv_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            work_q <= '0;
            cnt_q  <= '0;
            inv_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.i_valid) begin
                    work_q <= bus.i_data;
                    inv_q  <= bus.i_inv;
                    cnt_q  <= '0;
                end
                BUSY: begin
                    work_q <= work_d;
                    cnt_q  <= cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.o_data = work_q;
endmodule

// File: tb/tb_sub_bytes_seq.sv
// Directed bench for sub_bytes_seq: five instances (LANES 4,1,2,8,16) share one stimulus
// stream; results are compared against vectors and a generator-built S-box table.
module tb_sub_bytes_seq;
    localparam int NI = 5;

    function automatic int lanes_of(input int g);
        case (g)
            0:       return 4;
            1:       return 1;
            2:       return 2;
            3:       return 8;
            default: return 16;
        endcase
    endfunction

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         i_valid = 1'b0;
    logic [127:0] i_data = '0;
    logic         i_inv = 1'b0;
    logic         i_ready = 1'b1;
    logic [NI-1:0] ov, ordy;
    logic [127:0]  od [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : gl
        sub_bytes_seq_if bus ();
        assign bus.i_valid = i_valid;
        assign bus.i_data  = i_data;
        assign bus.i_inv   = i_inv;
        assign bus.i_ready = i_ready;
        assign ov[g]   = bus.o_valid;
        assign ordy[g] = bus.o_ready;
        assign od[g]   = bus.o_data;
        sub_bytes_seq #(.LANES(lanes_of(g))) dut (
            .clk(clk),
            .rst(rst),
            .bus(bus.slave)
        );
    end

    int nvec = 0;
    int nbad = 0;
    logic [7:0] sb  [256];
    logic [7:0] isb [256];

    typedef struct {
        logic [127:0] data;
        logic         inv;
        logic [127:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent S-box model: walk the multiplicative group with generator 3.
    task automatic build_model();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
        for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
    endtask

    task automatic wait_all_ready(input string name);
        int t;
        t = 0;
        while (ordy != '1 && t < 40) begin
            tick();
            t++;
        end
        if (ordy != '1) check({name, "/ready_timeout"}, 128'(ordy), 128'({NI{1'b1}}));
    endtask

    // Accept one state on every instance, then measure each latency and result.
    task automatic xact(input string name, input logic [127:0] data, input logic inv,
                        input logic [127:0] exp);
        int           lat  [NI];
        logic [127:0] got  [NI];
        i_ready = 1'b1;
        i_valid = 1'b0;
        wait_all_ready(name);
        i_data  = data;
        i_inv   = inv;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        i_data  = ~data;
        i_inv   = ~inv;
        for (int g = 0; g < NI; g++) begin
            lat[g] = -1;
            got[g] = 'x;
        end
        for (int c = 1; c <= 20; c++) begin
            tick();
            for (int g = 0; g < NI; g++)
                if (lat[g] < 0 && ov[g]) begin
                    lat[g] = c;
                    got[g] = od[g];
                end
        end
        for (int g = 0; g < NI; g++) begin
            check($sformatf("%s/L%0d/data", name, lanes_of(g)), got[g], exp);
            check($sformatf("%s/L%0d/latency", name, lanes_of(g)),
                  128'(lat[g]), 128'(16 / lanes_of(g)));
        end
    endtask

    initial begin
        vec_t vecs [8];
        logic [127:0] d, e, ie;
        vecs[0] = '{128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, 128'hd42711aee0bf98f1b8b45de51e415230};
        vecs[1] = '{128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, 128'h193de3bea0f4e22b9ac68d2ae9f84808};
        vecs[2] = '{{16{8'h00}}, 1'b0, {16{8'h63}}};
        vecs[3] = '{{16{8'hff}}, 1'b0, {16{8'h16}}};
        vecs[4] = '{{16{8'h63}}, 1'b1, {16{8'h00}}};
        vecs[5] = '{{16{8'h53}}, 1'b0, {16{8'hed}}};
        vecs[6] = '{{16{8'hed}}, 1'b1, {16{8'h53}}};
        vecs[7] = '{{16{8'h16}}, 1'b1, {16{8'hff}}};

        build_model();

        tick();
        tick();
        check("reset/o_valid", 128'(ov), 128'(0));
        check("reset/o_ready", 128'(ordy), 128'({NI{1'b1}}));
        for (int g = 0; g < NI; g++) check($sformatf("reset/L%0d/o_data", lanes_of(g)), od[g], '0);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 8; v++) xact($sformatf("vec%0d", v), vecs[v].data, vecs[v].inv, vecs[v].exp);

        // Backpressure: stall in DONE with noise on the upstream side.
        i_ready = 1'b0;
        i_data  = vecs[0].data;
        i_inv   = 1'b0;
        i_valid = 1'b1;
        tick();
        for (int c = 0; c < 18; c++) begin
            i_valid = 1'($urandom);
            i_data  = {$urandom, $urandom, $urandom, $urandom};
            i_inv   = 1'($urandom);
            tick();
        end
        for (int c = 0; c < 10; c++) begin
            check("stall/o_valid", 128'(ov), 128'({NI{1'b1}}));
            check("stall/o_ready", 128'(ordy), 128'(0));
            for (int g = 0; g < NI; g++)
                check($sformatf("stall/L%0d/o_data", lanes_of(g)), od[g], vecs[0].exp);
            i_valid = 1'($urandom);
            i_data  = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        tick();
        check("release/o_valid", 128'(ov), 128'(0));
        check("release/o_ready", 128'(ordy), 128'({NI{1'b1}}));

        // Reset during the second BUSY cycle of the LANES=4 instance.
        i_data  = vecs[5].data;
        i_inv   = 1'b0;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst/o_valid", 128'(ov), 128'(0));
        check("midrst/o_ready", 128'(ordy), 128'({NI{1'b1}}));
        for (int g = 0; g < NI; g++) check($sformatf("midrst/L%0d/o_data", lanes_of(g)), od[g], '0);
        xact("after_rst", vecs[0].data, 1'b0, vecs[0].exp);

        for (int b = 0; b < 16; b++) begin
            for (int j = 0; j < 16; j++) begin
                d[127 - 8*j -: 8]  = 8'(b*16 + j);
                e[127 - 8*j -: 8]  = sb[b*16 + j];
                ie[127 - 8*j -: 8] = isb[b*16 + j];
            end
            xact($sformatf("sbox_blk%0d", b), d, 1'b0, e);
            xact($sformatf("isbox_blk%0d", b), d, 1'b1, ie);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
